// File: rtl/spi_arbiter_if.sv
// Bundles the requester-facing and SPI-master-facing signals of spi_arbiter.
// The arbiter uses the slave modport; the requesters/SPI master side uses master.
interface spi_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int SS_W    = 3
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0]      lock;
  logic [16*NUM_REQ-1:0]   req_data;
  logic [SS_W*NUM_REQ-1:0] req_ss;
  logic [NUM_REQ-1:0]      gnt;
  logic [NUM_REQ-1:0]      done;
  logic                    lock_timeout;
  logic                    wrt_SPI;
  logic [15:0]             SPI_data;
  logic [SS_W-1:0]         ss;
  logic                    SPI_done;

  modport slave (
    input  req, lock, req_data, req_ss, SPI_done,
    output gnt, done, lock_timeout, wrt_SPI, SPI_data, ss
  );

  modport master (
    output req, lock, req_data, req_ss, SPI_done,
    input  gnt, done, lock_timeout, wrt_SPI, SPI_data, ss
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between several requesters, with an
// optional lock that lets the owner chain transfers until it releases or times out.
module spi_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int SS_W         = 3,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  spi_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [SS_W-1:0] SS_NONE = '0;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t             state;
  logic [NUM_REQ-1:0] pending;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      owner;
  logic [7:0]         hold_cnt;

  logic               win_valid;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      rr_idx;
  logic [PW-1:0]      sel_idx;
  logic [15:0]        sel_data;
  logic [SS_W-1:0]    sel_ss;
  logic [NUM_REQ-1:0] sel_oh;
  logic               issue;
  logic [NUM_REQ-1:0] accept;
  logic [PW-1:0]      ptr_next;

  // Scan downwards so the last hit is the first pending index at or after ptr.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    rr_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      rr_idx = PW'((int'(ptr) + k) % NUM_REQ);
      if (pending[rr_idx]) begin
        win_valid = 1'b1;
        win_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    sel_idx  = (state == HOLD) ? owner : win_idx;
    issue    = ((state == IDLE) && win_valid) || ((state == HOLD) && pending[owner]);
    sel_data = '0;
    sel_ss   = '0;
    sel_oh   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == PW'(i)) begin
        sel_data  = bus.req_data[16*i +: 16];
        sel_ss    = bus.req_ss[SS_W*i +: SS_W];
        sel_oh[i] = 1'b1;
      end
    end
  end

  // Requests are dropped when already pending or when the requester owns a BUSY bus.
  assign accept   = bus.req & ~pending & ((state == BUSY) ? ~bus.gnt : {NUM_REQ{1'b1}});
  assign ptr_next = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      pending          <= '0;
      ptr              <= '0;
      owner            <= '0;
      hold_cnt         <= '0;
      bus.gnt          <= '0;
      bus.done         <= '0;
      bus.lock_timeout <= 1'b0;
      bus.wrt_SPI      <= 1'b0;
      bus.SPI_data     <= 16'h0000;
      bus.ss           <= SS_NONE;
    end else begin
      bus.wrt_SPI      <= 1'b0;
      bus.done         <= '0;
      bus.lock_timeout <= 1'b0;
      pending          <= (pending | accept) & ~(issue ? sel_oh : '0);

      if (issue) begin
        owner        <= sel_idx;
        bus.SPI_data <= sel_data;
        bus.ss       <= sel_ss;
        bus.gnt      <= sel_oh;
        bus.wrt_SPI  <= 1'b1;
        state        <= BUSY;
      end else begin
        case (state)
          BUSY: begin
            if (bus.SPI_done) begin
              bus.done <= bus.gnt;
              bus.ss   <= SS_NONE;
              hold_cnt <= '0;
              if (bus.lock[owner]) begin
                state <= HOLD;
              end else begin
                state   <= IDLE;
                bus.gnt <= '0;
                ptr     <= ptr_next;
              end
            end
          end
          HOLD: begin
            // Released either voluntarily or after HOLD_TIMEOUT idle HOLD cycles.
            if (!bus.lock[owner] || (hold_cnt == 8'(HOLD_TIMEOUT - 1))) begin
              state            <= IDLE;
              bus.gnt          <= '0;
              ptr              <= ptr_next;
              bus.lock_timeout <= bus.lock[owner];
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: randomized words and request patterns checked
// against a transaction-level round-robin model and the documented cycle timing.
module tb_spi_arbiter;
  localparam int NR = 3;
  localparam int SW = 3;
  localparam int HT = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [NR-1:0] m_pending;
  int            m_ptr;
  logic [15:0]   words [NR];
  logic [SW-1:0] ssv   [NR];

  spi_arbiter_if #(.NUM_REQ(NR), .SS_W(SW)) bus ();

  spi_arbiter #(.NUM_REQ(NR), .SS_W(SW), .HOLD_TIMEOUT(HT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [15:0] d, input logic [SW-1:0] s);
    bus.req_data[16*i +: 16] = d;
    bus.req_ss[SW*i +: SW]   = s;
  endtask

  task automatic pulse_req(input logic [NR-1:0] mask);
    bus.req = mask;
    tick();
    bus.req = '0;
  endtask

  task automatic spi_done_after(input int n);
    repeat (n) tick();
    bus.SPI_done = 1'b1;
    tick();
    bus.SPI_done = 1'b0;
  endtask

  task automatic wait_wrt(output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.wrt_SPI === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.req = '0; bus.lock = '0; bus.SPI_done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    m_pending = '0;
    m_ptr     = 0;
  endtask

  function automatic int rr_pick(input logic [NR-1:0] pend, input int p);
    for (int k = 0; k < NR; k++) if (pend[(p + k) % NR]) return (p + k) % NR;
    return 0;
  endfunction

  task automatic test_reset();
    int stray;
    rst = 1'b1; bus.req = '1; bus.SPI_done = 1'b1; bus.lock = '0;
    tick(); tick();
    checks++; if (bus.gnt !== '0) begin errors++; $display("[TB] FAIL reset_gnt got %b want 000", bus.gnt); end
    checks++; if (bus.done !== '0) begin errors++; $display("[TB] FAIL reset_done got %b want 000", bus.done); end
    checks++; if (bus.lock_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_lock_timeout got %b want 0", bus.lock_timeout); end
    checks++; if (bus.wrt_SPI !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrt got %b want 0", bus.wrt_SPI); end
    checks++; if (bus.SPI_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data got %h want 0000", bus.SPI_data); end
    checks++; if (bus.ss !== '0) begin errors++; $display("[TB] FAIL reset_ss got %0d want 0", bus.ss); end
    bus.req = '0; bus.SPI_done = 1'b0; rst = 1'b0;
    stray = 0;
    repeat (4) begin tick(); if (bus.wrt_SPI !== 1'b0 || bus.gnt !== '0) stray++; end
    checks++; if (stray != 0) begin errors++; $display("[TB] FAIL reset_no_latch got %0d active cycles want 0", stray); end
    m_pending = '0;
    m_ptr     = 0;
  endtask

  task automatic test_single();
    int i;
    logic [NR-1:0] oh;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin
        i = 0; words[0] = 16'h1302; ssv[0] = 3'd2;
      end else begin
        i = $urandom_range(0, NR - 1); words[i] = 16'($urandom); ssv[i] = SW'($urandom_range(1, 7));
      end
      oh = NR'(1) << i;
      set_word(i, words[i], ssv[i]);
      pulse_req(oh);
      checks++; if (bus.wrt_SPI !== 1'b0) begin errors++; $display("[TB] FAIL single_early_wrt got %b want 0", bus.wrt_SPI); end
      tick();
      checks++; if (bus.wrt_SPI !== 1'b1) begin errors++; $display("[TB] FAIL single_wrt got %b want 1", bus.wrt_SPI); end
      checks++; if (bus.SPI_data !== words[i]) begin errors++; $display("[TB] FAIL single_data got %h want %h", bus.SPI_data, words[i]); end
      checks++; if (bus.ss !== ssv[i]) begin errors++; $display("[TB] FAIL single_ss got %0d want %0d", bus.ss, ssv[i]); end
      checks++; if (bus.gnt !== oh) begin errors++; $display("[TB] FAIL single_gnt got %b want %b", bus.gnt, oh); end
      tick();
      checks++; if (bus.wrt_SPI !== 1'b0 || bus.gnt !== oh) begin errors++; $display("[TB] FAIL single_wrt_width wrt %b gnt %b want 0 %b", bus.wrt_SPI, bus.gnt, oh); end
      spi_done_after((it == 0) ? 18 : $urandom_range(0, 8));
      checks++; if (bus.done !== oh) begin errors++; $display("[TB] FAIL single_done got %b want %b", bus.done, oh); end
      checks++; if (bus.gnt !== '0 || bus.ss !== '0) begin errors++; $display("[TB] FAIL single_release gnt %b ss %0d want 000 0", bus.gnt, bus.ss); end
      tick();
      checks++; if (bus.done !== '0) begin errors++; $display("[TB] FAIL single_done_width got %b want 000", bus.done); end
      m_ptr = (i + 1) % NR;
    end
  endtask

  task automatic test_contention();
    logic [NR-1:0] mask, exp_oh;
    int exp, lat;
    do_reset();
    for (int p = 0; p < 7; p++) begin
      case (p)
        0, 1:    mask = 3'b111;
        2:       mask = 3'b001;
        3:       mask = 3'b101;
        default: mask = NR'($urandom_range(1, 7));
      endcase
      for (int i = 0; i < NR; i++) begin
        if (mask[i]) begin
          words[i] = 16'($urandom); ssv[i] = SW'($urandom_range(1, 7));
          set_word(i, words[i], ssv[i]);
        end
      end
      pulse_req(mask);
      m_pending = m_pending | mask;
      while (m_pending != '0) begin
        exp = rr_pick(m_pending, m_ptr);
        exp_oh = NR'(1) << exp;
        m_pending[exp] = 1'b0;
        wait_wrt(lat);
        checks++; if (lat != 1) begin errors++; $display("[TB] FAIL rr_latency got %0d want 1", lat); end
        checks++; if (bus.gnt !== exp_oh) begin errors++; $display("[TB] FAIL rr_gnt got %b want %b", bus.gnt, exp_oh); end
        checks++; if (bus.SPI_data !== words[exp] || bus.ss !== ssv[exp]) begin errors++; $display("[TB] FAIL rr_word got %h/%0d want %h/%0d", bus.SPI_data, bus.ss, words[exp], ssv[exp]); end
        spi_done_after($urandom_range(0, 6));
        checks++; if (bus.done !== exp_oh || bus.gnt !== '0) begin errors++; $display("[TB] FAIL rr_done done %b gnt %b want %b 000", bus.done, bus.gnt, exp_oh); end
        m_ptr = (exp + 1) % NR;
      end
    end
  endtask

  task automatic test_lock();
    int lat, stray;
    bus.lock = 3'b010;
    words[1] = 16'h0A00; ssv[1] = SW'($urandom_range(1, 7));
    set_word(1, words[1], ssv[1]);
    pulse_req(3'b010);
    wait_wrt(lat);
    checks++; if (lat != 1 || bus.gnt !== 3'b010 || bus.SPI_data !== 16'h0A00) begin errors++; $display("[TB] FAIL lock_first lat %0d gnt %b data %h want 1 010 0a00", lat, bus.gnt, bus.SPI_data); end
    words[0] = 16'($urandom); ssv[0] = SW'($urandom_range(1, 7));
    set_word(0, words[0], ssv[0]);
    pulse_req(3'b001);
    for (int t = 0; t < 3; t++) begin
      spi_done_after($urandom_range(1, 4));
      checks++; if (bus.done !== 3'b010) begin errors++; $display("[TB] FAIL lock_done got %b want 010", bus.done); end
      checks++; if (bus.gnt !== 3'b010 || bus.ss !== '0) begin errors++; $display("[TB] FAIL lock_hold gnt %b ss %0d want 010 0", bus.gnt, bus.ss); end
      if (t < 2) begin
        words[1] = 16'($urandom); ssv[1] = SW'($urandom_range(1, 7));
        set_word(1, words[1], ssv[1]);
        pulse_req(3'b010);
        tick();
        checks++; if (bus.wrt_SPI !== 1'b1 || bus.gnt !== 3'b010 || bus.SPI_data !== words[1]) begin errors++; $display("[TB] FAIL lock_reissue wrt %b gnt %b data %h want 1 010 %h", bus.wrt_SPI, bus.gnt, bus.SPI_data, words[1]); end
      end
    end
    stray = 0;
    repeat (3) begin tick(); if (bus.wrt_SPI !== 1'b0 || bus.gnt !== 3'b010) stray++; end
    checks++; if (stray != 0) begin errors++; $display("[TB] FAIL lock_blocks_others got %0d bad cycles want 0", stray); end
    bus.lock = '0;
    tick();
    checks++; if (bus.gnt !== '0 || bus.lock_timeout !== 1'b0) begin errors++; $display("[TB] FAIL lock_release gnt %b lock_timeout %b want 000 0", bus.gnt, bus.lock_timeout); end
    tick();
    checks++; if (bus.wrt_SPI !== 1'b1 || bus.gnt !== 3'b001 || bus.SPI_data !== words[0]) begin errors++; $display("[TB] FAIL lock_next_owner wrt %b gnt %b data %h want 1 001 %h", bus.wrt_SPI, bus.gnt, bus.SPI_data, words[0]); end
    spi_done_after(2);
    checks++; if (bus.done !== 3'b001) begin errors++; $display("[TB] FAIL lock_next_done got %b want 001", bus.done); end
    m_ptr = 1;
  endtask

  task automatic test_timeout();
    int lat, c, dropped;
    bus.lock = 3'b100;
    words[2] = 16'($urandom); ssv[2] = SW'($urandom_range(1, 7));
    set_word(2, words[2], ssv[2]);
    pulse_req(3'b100);
    wait_wrt(lat);
    checks++; if (lat != 1 || bus.gnt !== 3'b100) begin errors++; $display("[TB] FAIL to_grant lat %0d gnt %b want 1 100", lat, bus.gnt); end
    words[0] = 16'($urandom); ssv[0] = SW'($urandom_range(1, 7));
    set_word(0, words[0], ssv[0]);
    pulse_req(3'b001);
    spi_done_after($urandom_range(0, 5));
    checks++; if (bus.done !== 3'b100) begin errors++; $display("[TB] FAIL to_done got %b want 100", bus.done); end
    c = 1; dropped = 0;
    while (bus.lock_timeout !== 1'b1 && c < HT + 6) begin
      if (bus.gnt !== 3'b100) dropped++;
      tick();
      c++;
    end
    checks++; if (c != HT + 1) begin errors++; $display("[TB] FAIL to_cycles got pulse at cycle %0d want %0d", c, HT + 1); end
    checks++; if (dropped != 0 || bus.gnt !== '0) begin errors++; $display("[TB] FAIL to_gnt early drops %0d gnt %b want 0 000", dropped, bus.gnt); end
    tick();
    checks++; if (bus.lock_timeout !== 1'b0 || bus.wrt_SPI !== 1'b1 || bus.gnt !== 3'b001 || bus.SPI_data !== words[0]) begin errors++; $display("[TB] FAIL to_next lt %b wrt %b gnt %b data %h want 0 1 001 %h", bus.lock_timeout, bus.wrt_SPI, bus.gnt, bus.SPI_data, words[0]); end
    bus.lock = '0;
    spi_done_after(1);
    checks++; if (bus.done !== 3'b001) begin errors++; $display("[TB] FAIL to_next_done got %b want 001", bus.done); end
    m_ptr = 1;
  endtask

  task automatic test_spurious();
    int extra;
    bus.SPI_done = 1'b1;
    tick();
    bus.SPI_done = 1'b0;
    checks++; if (bus.done !== '0 || bus.gnt !== '0 || bus.wrt_SPI !== 1'b0) begin errors++; $display("[TB] FAIL spur_idle done %b gnt %b wrt %b want 000 000 0", bus.done, bus.gnt, bus.wrt_SPI); end
    tick();
    words[1] = 16'($urandom); ssv[1] = SW'($urandom_range(1, 7));
    set_word(1, words[1], ssv[1]);
    bus.req = 3'b010; tick();
    bus.req = 3'b010; tick();
    bus.req = '0;
    checks++; if (bus.wrt_SPI !== 1'b1 || bus.gnt !== 3'b010 || bus.SPI_data !== words[1]) begin errors++; $display("[TB] FAIL dup_grant wrt %b gnt %b data %h want 1 010 %h", bus.wrt_SPI, bus.gnt, bus.SPI_data, words[1]); end
    tick();
    pulse_req(3'b010);
    spi_done_after(3);
    checks++; if (bus.done !== 3'b010) begin errors++; $display("[TB] FAIL dup_done got %b want 010", bus.done); end
    extra = 0;
    repeat (12) begin tick(); if (bus.wrt_SPI === 1'b1) extra++; end
    checks++; if (extra != 0 || bus.gnt !== '0) begin errors++; $display("[TB] FAIL dup_single_transfer extra %0d gnt %b want 0 000", extra, bus.gnt); end
    m_ptr = 2;
  endtask

  task automatic test_reset_mid();
    int stray;
    words[0] = 16'($urandom) | 16'h0001; ssv[0] = SW'($urandom_range(1, 7));
    set_word(0, words[0], ssv[0]);
    pulse_req(3'b001);
    tick();
    checks++; if (bus.wrt_SPI !== 1'b1 || bus.gnt !== 3'b001) begin errors++; $display("[TB] FAIL rmid_grant wrt %b gnt %b want 1 001", bus.wrt_SPI, bus.gnt); end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.gnt !== '0 || bus.wrt_SPI !== 1'b0 || bus.done !== '0 || bus.lock_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ctrl gnt %b wrt %b done %b lt %b want 000 0 000 0", bus.gnt, bus.wrt_SPI, bus.done, bus.lock_timeout); end
    checks++; if (bus.SPI_data !== 16'h0000 || bus.ss !== '0) begin errors++; $display("[TB] FAIL rmid_word data %h ss %0d want 0000 0", bus.SPI_data, bus.ss); end
    stray = 0;
    repeat (4) begin tick(); if (bus.done !== '0 || bus.wrt_SPI !== 1'b0) stray++; end
    checks++; if (stray != 0) begin errors++; $display("[TB] FAIL rmid_no_done got %0d bad cycles want 0", stray); end
    words[1] = 16'($urandom); ssv[1] = SW'($urandom_range(1, 7));
    set_word(1, words[1], ssv[1]);
    pulse_req(3'b010);
    tick();
    checks++; if (bus.wrt_SPI !== 1'b1 || bus.gnt !== 3'b010 || bus.SPI_data !== words[1] || bus.ss !== ssv[1]) begin errors++; $display("[TB] FAIL rmid_after wrt %b gnt %b data %h ss %0d want 1 010 %h %0d", bus.wrt_SPI, bus.gnt, bus.SPI_data, bus.ss, words[1], ssv[1]); end
    spi_done_after(2);
    checks++; if (bus.done !== 3'b010) begin errors++; $display("[TB] FAIL rmid_after_done got %b want 010", bus.done); end
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0; bus.lock = '0; bus.req_data = '0; bus.req_ss = '0; bus.SPI_done = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_lock();
    test_timeout();
    test_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
